// File: rtl/output_limit_ctrl_pkg.sv
// Shared types and constants for the output-limit controller that gates
// hs IO reads from the application output FIFO.
package output_limit_ctrl_pkg;

    localparam int LIMIT_WIDTH_DEF = 16;
    localparam int AVAIL_WIDTH_DEF = 17;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Vendor-command address of the register-output-limit request.
    localparam logic [7:0] VC_REG_OUTPUT_LIMIT = 8'h85;

endpackage

// File: rtl/output_limit_ctrl_updown_counter.sv
// Up/down word counter that saturates at all-ones and raises a sticky
// overflow flag when an increment arrives at the maximum.
module updown_counter #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             overflow
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (inc && !dec) begin
            if (count == '1) begin
                overflow <= 1'b1;
            end else begin
                count <= count + WIDTH'(1);
            end
        end else if (dec && !inc && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/output_limit_ctrl.sv
// Snapshots the buffered-word count on a register-limit strobe and then lets
// the hs IO FSM read exactly that many words from the output FIFO.
module output_limit_ctrl
    import output_limit_ctrl_pkg::*;
#(
    parameter int LIMIT_WIDTH = LIMIT_WIDTH_DEF,
    parameter int AVAIL_WIDTH = AVAIL_WIDTH_DEF
) (
    input  logic                   IFCLK,
    input  logic                   rst,
    input  logic                   output_mode_limit,
    input  logic                   reg_output_limit,
    input  logic                   fifo_wr_en,
    input  logic                   fifo_empty,
    input  logic                   rd_req,
    output logic                   fifo_rd_en,
    output logic [LIMIT_WIDTH-1:0] output_limit,
    output logic                   output_limit_not_done,
    output logic                   err_overflow,
    output logic                   state_dbg
);

    // Handshake: a word moves from the FIFO exactly in a cycle where
    // fifo_rd_en is high; rd_req is the hs IO's per-cycle request and
    // fifo_empty the FIFO's "no word available" flag.

    localparam logic [AVAIL_WIDTH-1:0] SNAP_MAX = AVAIL_WIDTH'({LIMIT_WIDTH{1'b1}});

    logic [AVAIL_WIDTH-1:0] avail;
    logic [LIMIT_WIDTH-1:0] snap;
    state_t                 state_q, state_d;
    logic [LIMIT_WIDTH-1:0] remaining_q, remaining_d;
    logic [LIMIT_WIDTH-1:0] limit_q, limit_d;
    logic                   not_done_q, not_done_d;

    updown_counter #(
        .WIDTH(AVAIL_WIDTH)
    ) u_avail (
        .clk     (IFCLK),
        .rst     (rst),
        .inc     (fifo_wr_en),
        .dec     (fifo_rd_en),
        .count   (avail),
        .overflow(err_overflow)
    );

    // The grant cannot exceed what output_limit can express.
    always_comb begin
        if (avail > SNAP_MAX) begin
            snap = '1;
        end else begin
            snap = avail[LIMIT_WIDTH-1:0];
        end
    end

    always_comb begin
        fifo_rd_en = 1'b0;
        if (!rst && rd_req && !fifo_empty) begin
            if (!output_mode_limit) begin
                fifo_rd_en = 1'b1;
            end else if ((state_q == ST_SEND) && (remaining_q != '0)) begin
                fifo_rd_en = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        limit_d     = limit_q;
        not_done_d  = not_done_q;
        case (state_q)
            ST_IDLE: begin
                if (reg_output_limit) begin
                    if (output_mode_limit) begin
                        limit_d     = snap;
                        remaining_d = snap;
                        if (snap != '0) begin
                            state_d    = ST_SEND;
                            not_done_d = 1'b1;
                        end
                    end else begin
                        limit_d = '0;
                    end
                end
            end
            ST_SEND: begin
                // Leaving limited mode abandons the grant; output_limit stays
                // so the host can still read what was granted.
                if (!output_mode_limit) begin
                    state_d     = ST_IDLE;
                    remaining_d = '0;
                    not_done_d  = 1'b0;
                end else if (fifo_rd_en) begin
                    remaining_d = remaining_q - LIMIT_WIDTH'(1);
                    if (remaining_q == LIMIT_WIDTH'(1)) begin
                        state_d    = ST_IDLE;
                        not_done_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge IFCLK) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            limit_q     <= '0;
            not_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            limit_q     <= limit_d;
            not_done_q  <= not_done_d;
        end
    end

    assign output_limit          = limit_q;
    assign output_limit_not_done = not_done_q;
    assign state_dbg             = state_q;

endmodule
